// File: rtl/spike_row_feeder.sv
// Streams in_ch*img_size spike rows from the row RAM to the maxpool input over valid/ready.
// Optional statistics outputs are enabled with `define SPIKE_FEEDER_STAT_EN.
module spike_row_feeder #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 16
) (
  input  logic              s_clk,
  input  logic              s_rst,
  input  logic              code_valid,
  input  logic [15:0]       conv_in_ch,
  input  logic [15:0]       conv_img_size,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic              o_spikes_valid,
  output logic [DATA_W-1:0] o_spikes,
  input  logic              i_spikes_ready,
  output logic              o_busy,
  output logic              o_feed_done,
`ifdef SPIKE_FEEDER_STAT_EN
  output logic [31:0]       o_stat_beats,
  output logic [31:0]       o_stat_stalls,
`endif
  output logic [1:0]        o_dbg_state
);

  // Valid/ready: a beat moves on a rising edge with o_spikes_valid && i_spikes_ready; while
  // valid is high and ready low, o_spikes and o_spikes_valid hold. Valid is a pure flop output.
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [31:0]         total_q, total_d;
  logic [31:0]         issued_q, issued_d;
  logic [31:0]         accepted_q, accepted_d;
  logic                inflight_q, inflight_d;
  logic [1:0]          count_q, count_d;
  logic [DATA_W-1:0]   head_q, head_d;
  logic [DATA_W-1:0]   tail_q, tail_d;
  logic [31:0]         product;
  logic [2:0]          occupancy;
  logic                pop;
  logic                push;
  logic                credit_ok;

  assign o_spikes       = head_q;
  assign o_spikes_valid = (count_q != 2'd0);
  assign o_dbg_state    = state_q;

  always_comb begin
    pop       = (count_q != 2'd0) && i_spikes_ready;
    push      = inflight_q;
    product   = 32'(conv_in_ch) * 32'(conv_img_size);
    // A read is allowed only if its data will find a free slot when it lands.
    occupancy = {1'b0, count_q} + {2'b00, inflight_q};
    credit_ok = occupancy < (3'd2 + {2'b00, pop});
  end

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    total_d     = total_q;
    issued_d    = issued_q;
    accepted_d  = accepted_q + {31'd0, pop};
    ram_rd_en   = 1'b0;
    ram_rd_addr = base_q + issued_q[ADDR_W-1:0];
    o_busy      = 1'b0;
    o_feed_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (code_valid) begin
          base_d     = base_addr;
          total_d    = product;
          issued_d   = 32'd0;
          accepted_d = 32'd0;
          if (product == 32'd0) begin
            state_d = ST_DONE;
          end else begin
            // First read leaves with the start strobe to hide the RAM latency.
            ram_rd_en   = 1'b1;
            ram_rd_addr = base_addr;
            issued_d    = 32'd1;
            state_d     = (product == 32'd1) ? ST_DRAIN : ST_RUN;
          end
        end
      end
      ST_RUN: begin
        o_busy = 1'b1;
        if ((issued_q < total_q) && credit_ok) begin
          ram_rd_en = 1'b1;
          issued_d  = issued_q + 32'd1;
        end
        if (issued_d == total_q) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        o_busy = 1'b1;
        if (pop && (accepted_q + 32'd1 == total_q)) state_d = ST_DONE;
      end
      ST_DONE: begin
        o_feed_done = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    inflight_d = ram_rd_en;
    case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) head_d = ram_rd_data;
        else                 tail_d = ram_rd_data;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          head_d = ram_rd_data;
        end else begin
          head_d = tail_q;
          tail_d = ram_rd_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge s_clk) begin
    if (s_rst) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      total_q    <= '0;
      issued_q   <= '0;
      accepted_q <= '0;
      inflight_q <= 1'b0;
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      total_q    <= total_d;
      issued_q   <= issued_d;
      accepted_q <= accepted_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

`ifdef SPIKE_FEEDER_STAT_EN
  logic [31:0] beats_q, beats_d;
  logic [31:0] stalls_q, stalls_d;

  assign o_stat_beats  = beats_q;
  assign o_stat_stalls = stalls_q;

  always_comb begin
    beats_d  = beats_q;
    stalls_d = stalls_q;
    if ((state_q == ST_IDLE) && code_valid) begin
      beats_d  = '0;
      stalls_d = '0;
    end else begin
      if (pop && (beats_q != '1)) beats_d = beats_q + 32'd1;
      if (o_spikes_valid && !i_spikes_ready && (stalls_q != '1)) stalls_d = stalls_q + 32'd1;
    end
  end

  always_ff @(posedge s_clk) begin
    if (s_rst) begin
      beats_q  <= '0;
      stalls_q <= '0;
    end else begin
      beats_q  <= beats_d;
      stalls_q <= stalls_d;
    end
  end
`endif

endmodule

// File: tb/tb_spike_row_feeder.sv
// Bench for spike_row_feeder: RAM model, randomized ready patterns, nested-loop reference model.
module tb_spike_row_feeder;
  localparam int DW = 128;
  localparam int AW = 16;

  logic          s_clk = 1'b0;
  logic          s_rst = 1'b1;
  logic          code_valid = 1'b0;
  logic [15:0]   conv_in_ch = '0;
  logic [15:0]   conv_img_size = '0;
  logic [AW-1:0] base_addr = '0;
  logic          ram_rd_en;
  logic [AW-1:0] ram_rd_addr;
  logic [DW-1:0] ram_rd_data = '0;
  logic          o_spikes_valid;
  logic [DW-1:0] o_spikes;
  logic          i_spikes_ready = 1'b1;
  logic          o_busy;
  logic          o_feed_done;
  logic [1:0]    dbg_state;
`ifdef SPIKE_FEEDER_STAT_EN
  logic [31:0]   stat_beats;
  logic [31:0]   stat_stalls;
`endif

  spike_row_feeder #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .s_clk(s_clk), .s_rst(s_rst), .code_valid(code_valid),
    .conv_in_ch(conv_in_ch), .conv_img_size(conv_img_size), .base_addr(base_addr),
    .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
    .o_spikes_valid(o_spikes_valid), .o_spikes(o_spikes), .i_spikes_ready(i_spikes_ready),
    .o_busy(o_busy), .o_feed_done(o_feed_done),
`ifdef SPIKE_FEEDER_STAT_EN
    .o_stat_beats(stat_beats), .o_stat_stalls(stat_stalls),
`endif
    .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 s_clk = ~s_clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [15:0] salt = 16'h1357;

  always @(posedge s_clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] row_of(input logic [AW-1:0] a);
    return {a ^ 16'h5A5A, ~a, a * 16'd31, a, 16'hC0DE, a + 16'h1234, a ^ salt, salt};
  endfunction

  // RAM: data valid the cycle after the read strobe
  always @(posedge s_clk) if (ram_rd_en) ram_rd_data <= row_of(ram_rd_addr);

  // ---------------- ready driver ----------------
  int ready_mode = 0;
  int hold_cnt = 0;
  initial begin
    forever begin
      @(posedge s_clk);
      #1;
      case (ready_mode)
        0: i_spikes_ready = 1'b1;
        1: i_spikes_ready = ~i_spikes_ready;
        2: i_spikes_ready = ($urandom_range(0, 3) != 0);
        default: begin
          i_spikes_ready = (hold_cnt == 0);
          if (hold_cnt > 0) hold_cnt--;
        end
      endcase
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] got_q[$];
  int            got_cyc[$];
  logic [AW-1:0] rd_addr_q[$];
  logic [AW-1:0] exp_addr_q[$];
  int            done_cnt = 0;
  int            done_cyc = 0;
  int            stall_viol = 0;
  int            stall_cnt = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;

  always @(negedge s_clk) begin
    if (s_rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!o_spikes_valid || (o_spikes !== prev_data))) stall_viol++;
      if (o_spikes_valid && i_spikes_ready) begin
        got_q.push_back(o_spikes);
        got_cyc.push_back(cyc);
      end
      if (o_spikes_valid && !i_spikes_ready) stall_cnt++;
      prev_stall = o_spikes_valid && !i_spikes_ready;
      prev_data  = o_spikes;
      if (o_feed_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (ram_rd_en) rd_addr_q.push_back(ram_rd_addr);
    end
  end

  task automatic clear_obs();
    got_q.delete(); got_cyc.delete(); rd_addr_q.delete();
    done_cnt = 0; stall_viol = 0; stall_cnt = 0;
  endtask

  // Reference: channel-major, row-minor address list and the rows the RAM holds there.
  task automatic build_exp(input int ch, input int img, input logic [AW-1:0] base);
    exp_q.delete(); exp_addr_q.delete();
    for (int c = 0; c < ch; c++) begin
      for (int r = 0; r < img; r++) begin
        logic [AW-1:0] a;
        a = base + 16'(c * img + r);
        exp_addr_q.push_back(a);
        exp_q.push_back(row_of(a));
      end
    end
  endtask

  task automatic sb_check(input string name);
    logic [DW-1:0] g, e;
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s beat_count got=%0d exp=%0d", name, got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL %s beat_data got=%h exp=%h", name, g, e);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_layer(input int ch, input int img, input logic [AW-1:0] base,
                             output int cv_cyc);
    @(posedge s_clk); #1;
    code_valid = 1'b1; conv_in_ch = ch[15:0]; conv_img_size = img[15:0]; base_addr = base;
    cv_cyc = cyc;
    @(posedge s_clk); #1;
    code_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(negedge s_clk);
      n++;
    end
    ok = (done_cnt != 0);
    repeat (3) @(negedge s_clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    s_rst = 1'b1;
    repeat (3) @(posedge s_clk);
    #1;
    checks++; if (ram_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got=%b exp=0", ram_rd_en); end
    checks++; if (ram_rd_addr !== '0) begin errors++; $display("FAIL reset_rd_addr got=%h exp=0", ram_rd_addr); end
    checks++; if (o_spikes_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", o_spikes_valid); end
    checks++; if (o_spikes !== '0) begin errors++; $display("FAIL reset_spikes got=%h exp=0", o_spikes); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
    checks++; if (o_feed_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", o_feed_done); end
`ifdef SPIKE_FEEDER_STAT_EN
    checks++; if (stat_beats !== 32'd0) begin errors++; $display("FAIL reset_stat_beats got=%0d exp=0", stat_beats); end
`endif
    s_rst = 1'b0;
  endtask

  task automatic test_basic();
    int cv; bit ok; int last;
    ready_mode = 0; clear_obs(); salt = 16'($urandom);
    build_exp(2, 4, 16'h0010);
    start_layer(2, 4, 16'h0010, cv);
    wait_done(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_timeout done=0 exp=1"); end
    checks++; if (rd_addr_q.size() != 8) begin errors++; $display("FAIL basic_reads got=%0d exp=8", rd_addr_q.size()); end
    for (int i = 0; i < rd_addr_q.size() && i < exp_addr_q.size(); i++) begin
      checks++;
      if (rd_addr_q[i] !== exp_addr_q[i]) begin
        errors++; $display("FAIL basic_addr[%0d] got=%h exp=%h", i, rd_addr_q[i], exp_addr_q[i]);
      end
    end
    checks++;
    if (got_cyc.size() == 0 || got_cyc[0] - cv != 2) begin
      errors++; $display("FAIL basic_latency got=%0d exp=2", got_cyc.size() == 0 ? -1 : got_cyc[0] - cv);
    end
    for (int i = 1; i < got_cyc.size(); i++) begin
      checks++;
      if (got_cyc[i] != got_cyc[0] + i) begin
        errors++; $display("FAIL basic_b2b[%0d] got=%0d exp=%0d", i, got_cyc[i], got_cyc[0] + i);
      end
    end
    last = (got_cyc.size() == 0) ? -10 : got_cyc[got_cyc.size() - 1];
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL basic_done_pulses got=%0d exp=1", done_cnt); end
    checks++; if (done_cyc != last + 1) begin errors++; $display("FAIL basic_done_cycle got=%0d exp=%0d", done_cyc, last + 1); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after got=%b exp=0", o_busy); end
`ifdef SPIKE_FEEDER_STAT_EN
    checks++; if (stat_beats !== 32'd8) begin errors++; $display("FAIL basic_stat_beats got=%0d exp=8", stat_beats); end
    checks++; if (stat_stalls !== 32'd0) begin errors++; $display("FAIL basic_stat_stalls got=%0d exp=0", stat_stalls); end
`endif
    sb_check("basic");
  endtask

  task automatic test_toggle();
    int cv; bit ok; logic [AW-1:0] base;
    ready_mode = 1; clear_obs(); salt = 16'($urandom); base = 16'($urandom);
    build_exp(1, 6, base);
    start_layer(1, 6, base, cv);
    wait_done(300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL toggle_timeout done=0 exp=1"); end
    checks++; if (stall_viol != 0) begin errors++; $display("FAIL toggle_stable got=%0d exp=0", stall_viol); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL toggle_done_pulses got=%0d exp=1", done_cnt); end
`ifdef SPIKE_FEEDER_STAT_EN
    checks++; if (stat_stalls !== 32'(stall_cnt)) begin errors++; $display("FAIL toggle_stat_stalls got=%0d exp=%0d", stat_stalls, stall_cnt); end
`endif
    sb_check("toggle");
  endtask

  task automatic test_stall20();
    int cv; bit ok; logic [AW-1:0] base;
    clear_obs(); salt = 16'($urandom); base = 16'($urandom);
    hold_cnt = 20; ready_mode = 3;
    build_exp(2, 4, base);
    start_layer(2, 4, base, cv);
    repeat (12) @(negedge s_clk);
    checks++; if (rd_addr_q.size() != 2) begin errors++; $display("FAIL stall_reads got=%0d exp=2", rd_addr_q.size()); end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL stall_beats got=%0d exp=0", got_q.size()); end
    wait_done(300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL stall_timeout done=0 exp=1"); end
    checks++; if (stall_viol != 0) begin errors++; $display("FAIL stall_stable got=%0d exp=0", stall_viol); end
    sb_check("stall20");
    ready_mode = 0;
  endtask

  task automatic test_zero();
    int cv; bit ok;
    int zc[2];
    int zi[2];
    zc[0] = 0; zi[0] = 5; zc[1] = 3; zi[1] = 0;
    ready_mode = 0;
    for (int k = 0; k < 2; k++) begin
      clear_obs();
      start_layer(zc[k], zi[k], 16'($urandom), cv);
      wait_done(20, ok);
      checks++; if (!ok) begin errors++; $display("FAIL zero%0d_timeout done=0 exp=1", k); end
      checks++; if (rd_addr_q.size() != 0) begin errors++; $display("FAIL zero%0d_reads got=%0d exp=0", k, rd_addr_q.size()); end
      checks++;
      if (done_cyc - cv < 1 || done_cyc - cv > 2) begin
        errors++; $display("FAIL zero%0d_done_delay got=%0d exp=1..2", k, done_cyc - cv);
      end
      checks++; if (got_q.size() != 0) begin errors++; $display("FAIL zero%0d_beats got=%0d exp=0", k, got_q.size()); end
      checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL zero%0d_busy got=%b exp=0", k, o_busy); end
    end
  endtask

  task automatic test_wrap();
    int cv; bit ok;
    ready_mode = 0; clear_obs(); salt = 16'($urandom);
    build_exp(1, 4, 16'hFFFE);
    start_layer(1, 4, 16'hFFFE, cv);
    @(posedge s_clk); #1;
    code_valid = 1'b1; conv_in_ch = 16'd3; conv_img_size = 16'd3; base_addr = 16'h0100;
    @(posedge s_clk); #1;
    code_valid = 1'b0;
    wait_done(100, ok);
    repeat (8) @(negedge s_clk);
    checks++; if (!ok) begin errors++; $display("FAIL wrap_timeout done=0 exp=1"); end
    checks++; if (rd_addr_q.size() != 4) begin errors++; $display("FAIL wrap_reads got=%0d exp=4", rd_addr_q.size()); end
    for (int i = 0; i < rd_addr_q.size() && i < exp_addr_q.size(); i++) begin
      checks++;
      if (rd_addr_q[i] !== exp_addr_q[i]) begin
        errors++; $display("FAIL wrap_addr[%0d] got=%h exp=%h", i, rd_addr_q[i], exp_addr_q[i]);
      end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL wrap_done_pulses got=%0d exp=1", done_cnt); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL wrap_busy got=%b exp=0", o_busy); end
    sb_check("wrap");
  endtask

  task automatic test_reset_mid();
    int cv; bit ok; int n; logic [AW-1:0] base;
    ready_mode = 0; clear_obs(); salt = 16'($urandom);
    start_layer(2, 8, 16'($urandom), cv);
    n = 0;
    while (got_q.size() < 3 && n < 100) begin @(negedge s_clk); n++; end
    checks++; if (got_q.size() < 3) begin errors++; $display("FAIL rstmid_reach got=%0d exp=3", got_q.size()); end
    @(posedge s_clk); #1; s_rst = 1'b1;
    @(posedge s_clk); #1; s_rst = 1'b0;
    checks++; if (ram_rd_en !== 1'b0) begin errors++; $display("FAIL rstmid_rd_en got=%b exp=0", ram_rd_en); end
    checks++; if (ram_rd_addr !== '0) begin errors++; $display("FAIL rstmid_rd_addr got=%h exp=0", ram_rd_addr); end
    checks++; if (o_spikes_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got=%b exp=0", o_spikes_valid); end
    checks++; if (o_spikes !== '0) begin errors++; $display("FAIL rstmid_spikes got=%h exp=0", o_spikes); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", o_busy); end
    checks++; if (o_feed_done !== 1'b0) begin errors++; $display("FAIL rstmid_done got=%b exp=0", o_feed_done); end
    repeat (2) @(negedge s_clk);
    clear_obs(); salt = 16'($urandom); base = 16'($urandom);
    build_exp(1, 5, base);
    start_layer(1, 5, base, cv);
    wait_done(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_timeout done=0 exp=1"); end
    checks++;
    if (got_cyc.size() == 0 || got_cyc[0] - cv != 2) begin
      errors++; $display("FAIL rstmid_latency got=%0d exp=2", got_cyc.size() == 0 ? -1 : got_cyc[0] - cv);
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL rstmid_done_pulses got=%0d exp=1", done_cnt); end
    sb_check("rstmid");
  endtask

  task automatic test_random();
    int cv; bit ok; int ch; int img; logic [AW-1:0] base;
    ready_mode = 2;
    for (int k = 0; k < 5; k++) begin
      clear_obs(); salt = 16'($urandom); base = 16'($urandom);
      ch = $urandom_range(1, 3); img = $urandom_range(1, 5);
      build_exp(ch, img, base);
      start_layer(ch, img, base, cv);
      wait_done(500, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rand%0d_timeout done=0 exp=1", k); end
      checks++; if (rd_addr_q.size() != ch * img) begin errors++; $display("FAIL rand%0d_reads got=%0d exp=%0d", k, rd_addr_q.size(), ch * img); end
      checks++; if (stall_viol != 0) begin errors++; $display("FAIL rand%0d_stable got=%0d exp=0", k, stall_viol); end
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL rand%0d_done_pulses got=%0d exp=1", k, done_cnt); end
      sb_check($sformatf("rand%0d", k));
    end
    ready_mode = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_toggle();
    test_stall20();
    test_zero();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
